cpu_run_ctrl: RTL and testbench

Hardware run controller for the pipelined DLX CPU.
- Gates the CPU with a clock-enable and watches the fetch-stage PC.
- Halts the CPU once the PC reaches a programmed end address, after draining the pipeline.
- Also halts on a cycle-budget timeout.
- Reports cycle and PC-advance counts.
- Sits between the top-level harness/host and the CPU's enable input. This replaces open-loop clocking to a PC limit.

---
 rtl/cpu_run_ctrl_pkg.sv | 19 +
 rtl/run_sat_counter.sv | 28 ++
 rtl/cpu_run_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the DLX run controller.
// The optional stuck-PC detector in the top level is enabled with CPU_RUN_CTRL_STUCK_EN.
package cpu_run_ctrl_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    // Base of the DLX text segment; a fresh program starts fetching here.
    localparam logic [31:0] DLX_TEXT_BASE = 32'h0040_0000;

    // Default width of the run counters and of the cycle budget.
    localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/run_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Clear has priority over enable.
module run_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    // Count state: clear, else increment while not yet saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined DLX CPU: gates the CPU clock-enable,
// stops on a PC end address (after draining the pipeline) or a cycle budget,
// and counts enabled cycles and PC advances.
// Define CPU_RUN_CTRL_STUCK_EN to add the stuck-PC detector and its 'stuck' output.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CNT_W        = DEFAULT_CNT_W,
    parameter logic [31:0] RESET_PC     = DLX_TEXT_BASE
`ifdef CPU_RUN_CTRL_STUCK_EN
    ,
    parameter int          STUCK_LIMIT  = 64
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      pc_lim,
    input  logic [CNT_W-1:0] max_cycles,
    input  logic [31:0]      pc_if,
    output logic             cpu_en,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] pc_adv_cnt
`ifdef CPU_RUN_CTRL_STUCK_EN
    ,
    output logic             stuck
`endif
);

    // Drain counter only needs to hold DRAIN_CYCLES-1.
    localparam int           DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam bit           DRAIN_EN   = (DRAIN_CYCLES > 0);

    run_state_t      state_reg, state_next;
    logic [31:0]     lim_reg;
    logic [CNT_W-1:0] budget_reg;
    logic [DW-1:0]   drain_cnt_reg;
    logic [31:0]     pc_prev_reg;
    logic            cpu_en_reg, running_reg, done_reg, timeout_reg;

    logic            accept, active, pc_changed, lim_hit, budget_hit;
    logic            timeout_set;
    logic [CNT_W:0]  cycle_cnt_inc;

    assign accept        = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign active        = (state_reg == RUN) || (state_reg == DRAIN);
    assign pc_changed    = (pc_if != pc_prev_reg);
    assign lim_hit       = (pc_if >= lim_reg);
    // Widened so a saturated counter never aliases onto a budget value.
    assign cycle_cnt_inc = {1'b0, cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign budget_hit    = (budget_reg != '0) && (cycle_cnt_inc == {1'b0, budget_reg});

    run_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (active),
        .cnt   (cycle_cnt)
    );

    run_sat_counter #(.W(CNT_W)) u_pc_adv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (active && pc_changed),
        .cnt   (pc_adv_cnt)
    );

`ifdef CPU_RUN_CTRL_STUCK_EN
    localparam int SW = $clog2(STUCK_LIMIT + 1);

    logic [SW-1:0] stuck_cnt;
    logic          stuck_hit, stuck_set, stuck_reg;

    // Counts consecutive RUN cycles without a PC change.
    run_sat_counter #(.W(SW)) u_stuck_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept || (active && pc_changed)),
        .en    ((state_reg == RUN) && !pc_changed),
        .cnt   (stuck_cnt)
    );

    assign stuck_hit = (state_reg == RUN) && !pc_changed &&
                       (({1'b0, stuck_cnt} + {{SW{1'b0}}, 1'b1}) == (SW+1)'(STUCK_LIMIT));
`endif

    // Next-state decode: PC limit beats budget, budget beats stuck detection.
    always_comb begin
        state_next  = state_reg;
        timeout_set = 1'b0;
`ifdef CPU_RUN_CTRL_STUCK_EN
        stuck_set   = 1'b0;
`endif
        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (lim_hit) begin
                    state_next = DRAIN_EN ? DRAIN : DONE;
                end else if (budget_hit) begin
                    state_next  = DONE;
                    timeout_set = 1'b1;
                end
`ifdef CPU_RUN_CTRL_STUCK_EN
                else if (stuck_hit) begin
                    state_next = DONE;
                    stuck_set  = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (drain_cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched run parameters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lim_reg       <= '0;
            budget_reg    <= '0;
            drain_cnt_reg <= '0;
            pc_prev_reg   <= RESET_PC;
            cpu_en_reg    <= 1'b0;
            running_reg   <= 1'b0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cpu_en_reg  <= (state_next == RUN) || (state_next == DRAIN);
            running_reg <= (state_next == RUN) || (state_next == DRAIN);
            done_reg    <= (state_next == DONE);

            if (accept) begin
                lim_reg     <= pc_lim;
                budget_reg  <= max_cycles;
                pc_prev_reg <= RESET_PC;
                timeout_reg <= 1'b0;
            end else if (active) begin
                pc_prev_reg <= pc_if;
                if (timeout_set) begin
                    timeout_reg <= 1'b1;
                end
            end

            if ((state_reg == RUN) && lim_hit) begin
                drain_cnt_reg <= DRAIN_LOAD;
            end else if ((state_reg == DRAIN) && (drain_cnt_reg != '0)) begin
                drain_cnt_reg <= drain_cnt_reg - {{(DW-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef CPU_RUN_CTRL_STUCK_EN
    // Sticky stuck flag, cleared only by a new run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_reg <= 1'b0;
        end else if (accept) begin
            stuck_reg <= 1'b0;
        end else if (stuck_set) begin
            stuck_reg <= 1'b1;
        end
    end

    assign stuck = stuck_reg;
`endif

    assign cpu_en  = cpu_en_reg;
    assign running = running_reg;
    assign done    = done_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed vector table, reset and
// saturation sequences, and randomized PC streams against a run-level model.
// Define CPU_RUN_CTRL_STUCK_EN to also exercise the stuck-PC detector.
module tb_cpu_run_ctrl;

    localparam int          CNT_W = 32;
    localparam int          DRAIN = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          N     = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [31:0]      pc_lim;
    logic [CNT_W-1:0] max_cycles;
    logic [31:0]      pc_if;
    logic             cpu_en, running, done, timeout;
    logic [CNT_W-1:0] cycle_cnt, pc_adv_cnt;
`ifdef CPU_RUN_CTRL_STUCK_EN
    logic             stuck, s_stuck;
`endif

    // Small-width instance used to observe counter saturation.
    logic             s_start;
    logic [31:0]      s_pc;
    logic             s_cpu_en, s_running, s_done, s_timeout;
    logic [3:0]       s_cycle_cnt, s_pc_adv_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] pcseq [N];

    always #5 clk = ~clk;

    cpu_run_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W), .RESET_PC(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pc_lim     (pc_lim),
        .max_cycles (max_cycles),
        .pc_if      (pc_if),
        .cpu_en     (cpu_en),
        .running    (running),
        .done       (done),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt),
        .pc_adv_cnt (pc_adv_cnt)
`ifdef CPU_RUN_CTRL_STUCK_EN
        ,
        .stuck      (stuck)
`endif
    );

    cpu_run_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4), .RESET_PC(BASE)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s_start),
        .pc_lim     (32'hFFFF_FFFF),
        .max_cycles (4'd0),
        .pc_if      (s_pc),
        .cpu_en     (s_cpu_en),
        .running    (s_running),
        .done       (s_done),
        .timeout    (s_timeout),
        .cycle_cnt  (s_cycle_cnt),
        .pc_adv_cnt (s_pc_adv_cnt)
`ifdef CPU_RUN_CTRL_STUCK_EN
        ,
        .stuck      (s_stuck)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, ":cpu_en"},     cpu_en,     0);
        chk({nm, ":running"},    running,    0);
        chk({nm, ":done"},       done,       0);
        chk({nm, ":timeout"},    timeout,    0);
        chk({nm, ":cycle_cnt"},  cycle_cnt,  0);
        chk({nm, ":pc_adv_cnt"}, pc_adv_cnt, 0);
    endtask

    task automatic fill_linear();
        for (int k = 0; k < N; k++) pcseq[k] = BASE + 32'(4 * k);
    endtask

    // Run-level model: find when the limit is first reached, decide whether
    // the budget expires strictly earlier, then count PC changes over the run.
    task automatic model(input logic [31:0] lim, input int mx,
                         output int cyc, output int adv, output bit to);
        int kl;
        logic [31:0] prev;
        kl = -1;
        for (int k = 0; k < N; k++) begin
            if (pcseq[k] >= lim) begin
                kl = k;
                break;
            end
        end
        if (mx != 0 && (kl < 0 || mx - 1 < kl)) begin
            cyc = mx;
            to  = 1'b1;
        end else begin
            cyc = (kl < 0) ? N : kl + 1 + DRAIN;
            to  = 1'b0;
        end
        adv  = 0;
        prev = BASE;
        for (int k = 0; k < cyc && k < N; k++) begin
            if (pcseq[k] != prev) adv++;
            prev = pcseq[k];
        end
    endtask

    // One run: start, feed pcseq one entry per enabled cycle until done.
    task automatic do_run(input string nm, input logic [31:0] lim, input logic [CNT_W-1:0] mx,
                          input int restart_at, input int rst_at,
                          input int exp_cyc, input int exp_adv, input bit exp_to);
        int k;
        bit fin;
        @(negedge clk);
        start      = 1'b1;
        pc_lim     = lim;
        max_cycles = mx;
        @(negedge clk);
        start = 1'b0;
        chk({nm, ":start_en"},   cpu_en,     1);
        chk({nm, ":start_run"},  running,    1);
        chk({nm, ":start_done"}, done,       0);
        chk({nm, ":start_to"},   timeout,    0);
        chk({nm, ":start_cyc"},  cycle_cnt,  0);
        chk({nm, ":start_adv"},  pc_adv_cnt, 0);
`ifdef CPU_RUN_CTRL_STUCK_EN
        chk({nm, ":start_stuck"}, stuck, 0);
`endif
        k   = 0;
        fin = 1'b0;
        while (!fin && k < N) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                chk({nm, ":en_during_run"}, cpu_en, 1);
                if (k == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk_idle_zero({nm, ":async_rst"});
                    @(negedge clk);
                    rst_n = 1'b1;
                    $display("[TB] run %s reset asserted at enabled cycle %0d", nm, k);
                    return;
                end
                if (k == restart_at) begin
                    start  = 1'b1;
                    pc_lim = 32'h0040_0020;
                end
                pc_if = pcseq[k];
                @(negedge clk);
                start = 1'b0;
                k++;
            end
        end
        if (!fin) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s:done_wait: got no done after %0d cycles, expected done", nm, k);
        end else begin
            chk({nm, ":enabled_cycles"}, k,          exp_cyc);
            chk({nm, ":cycle_cnt"},      cycle_cnt,  exp_cyc);
            chk({nm, ":pc_adv_cnt"},     pc_adv_cnt, exp_adv);
            chk({nm, ":timeout"},        timeout,    exp_to);
            chk({nm, ":cpu_en_off"},     cpu_en,     0);
            chk({nm, ":running_off"},    running,    0);
        end
        $display("[TB] run %s lim=0x%08h max=%0d cycles=%0d adv=%0d timeout=%0b",
                 nm, lim, mx, cycle_cnt, pc_adv_cnt, timeout);
    endtask

    typedef struct {
        logic [31:0] lim;
        logic [31:0] mx;
        int          restart_at;
        int          exp_cyc;
        int          exp_adv;
        bit          exp_to;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cyc, adv, mx, idx;
        bit to;
        logic [31:0] lim;

        rst_n = 1'b0; start = 1'b0; pc_lim = '0; max_cycles = '0; pc_if = BASE;
        s_start = 1'b0; s_pc = BASE;

        // Linear PC stream, step 4 from the text base.
        vecs[0] = '{32'h0040_0054, 0,  -1, 26, 25, 1'b0}; // normal end via drain
        vecs[1] = '{32'h0040_0100, 10, -1, 10,  9, 1'b1}; // budget timeout
        vecs[2] = '{32'h0040_0054, 22, -1, 26, 25, 1'b0}; // budget and limit same cycle
        vecs[3] = '{32'h0040_0054, 21, -1, 21, 20, 1'b1}; // budget one cycle earlier
        vecs[4] = '{32'h0040_0054, 0,   5, 26, 25, 1'b0}; // start while running ignored
        vecs[5] = '{BASE,          0,  -1,  5,  4, 1'b0}; // limit hit on first cycle
        vecs[6] = '{32'h0040_0100, 1,  -1,  1,  0, 1'b1}; // minimal budget

        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_zero("idle_after_reset");

        // Saturation: 20 enabled cycles into 4-bit counters.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            s_pc = BASE + 32'(4 * t);
            @(negedge clk);
        end
        chk("sat:cpu_en",     s_cpu_en,     1);
        chk("sat:cycle_cnt",  s_cycle_cnt,  15);
        chk("sat:pc_adv_cnt", s_pc_adv_cnt, 15);
        $display("[TB] run sat cycles=%0d adv=%0d", s_cycle_cnt, s_pc_adv_cnt);

        fill_linear();
        for (int i = 0; i < 7; i++) begin
            do_run($sformatf("vec%0d", i), vecs[i].lim, vecs[i].mx, vecs[i].restart_at, -1,
                   vecs[i].exp_cyc, vecs[i].exp_adv, vecs[i].exp_to);
        end

        // Asynchronous reset in the middle of DRAIN, then a clean run.
        do_run("rst_drain", 32'h0040_0054, 0, -1, 23, 0, 0, 1'b0);
        @(negedge clk);
        chk_idle_zero("after_rst_drain");
        do_run("after_rst", 32'h0040_0054, 0, -1, -1, 26, 25, 1'b0);

        // Randomized PC streams with stalls and small offsets on the limit.
        for (int r = 0; r < 20; r++) begin
            pcseq[0] = BASE + 32'(4 * $urandom_range(0, 2));
            for (int k = 1; k < N; k++)
                pcseq[k] = pcseq[k-1] + (($urandom_range(0, 3) == 0) ? 32'd0 : 32'd4);
            idx = $urandom_range(0, 120);
            lim = pcseq[idx] + 32'($urandom_range(0, 3));
            mx  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 100) : 0;
            model(lim, mx, cyc, adv, to);
            if (cyc >= N - 1) begin
                mx = 50;
                model(lim, mx, cyc, adv, to);
            end
            do_run($sformatf("rnd%0d", r), lim, mx, -1, -1, cyc, adv, to);
        end

`ifdef CPU_RUN_CTRL_STUCK_EN
        // PC held at a single address: ends on stuck detection.
        for (int k = 0; k < N; k++) pcseq[k] = 32'h0040_0010;
        do_run("stuck", 32'h0040_1000, 0, -1, -1, 65, 1, 1'b0);
        chk("stuck:flag", stuck, 1);
        chk("stuck:done", done,  1);
        fill_linear();
        do_run("after_stuck", 32'h0040_0054, 0, -1, -1, 26, 25, 1'b0);
        chk("after_stuck:flag", stuck, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
